// File: rtl/segasys1_romload_if.sv
// Host download stream plus paced ROM write bus.
// The master side drives the strobe and ROMRDY; the slave side is the download front-end.
interface segasys1_romload_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [24:0] ROMAD;
  logic [7:0]  ROMDT;
  logic        ROMEN;
  logic        ROMRDY;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ROMRDY,
    input  ioctl_wait, ROMAD, ROMDT, ROMEN
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ROMRDY,
    output ioctl_wait, ROMAD, ROMDT, ROMEN
  );
endinterface

// File: rtl/segasys1_romload.sv
// Download front-end: one-byte holding register, ROMEN one cycle after capture when ROMRDY is high,
// ioctl_wait stays high while a byte is held; classifies the decryption table at download end.
module segasys1_romload #(
  parameter logic [24:0] TBL_ADR = 25'h2C100,
  parameter logic [7:0]  SWP_OFS = 8'h80,
  parameter logic [7:0]  SWP_MAX = 8'd24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  segasys1_romload_if.slave       bus,
  output logic                    ROMCL,
  output logic [1:0]              dec_type,
  output logic                    dec_valid,
  output logic [24:0]             byte_cnt,
  output logic                    err_ovr
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_FIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        dl_q, dl_d;
  logic        pend_q, pend_d;
  logic [24:0] adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic [24:0] rad_q, rad_d;
  logic [7:0]  rdt_q, rdt_d;
  logic [24:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        seen_q, seen_d;
  logic        bad_q, bad_d;
  logic [7:0]  swp_q, swp_d;
  logic [1:0]  type_q, type_d;
  logic        valid_q, valid_d;

  logic        dl_rise;
  logic        issue;
  logic [24:0] off;
  logic        in_tbl;
  logic        in_swp;

  assign ROMCL   = clk;
  assign dl_rise = bus.ioctl_download & ~dl_q;
  assign issue   = pend_q & bus.ROMRDY;

  // Offset wraps below the table base, so the lower bound is checked on the raw address.
  assign off    = adr_q - TBL_ADR;
  assign in_tbl = (adr_q >= TBL_ADR) && (off <= 25'd255);
  assign in_swp = in_tbl && (off[7:0] >= SWP_OFS);

  always_comb begin
    state_d = state_q;
    dl_d    = bus.ioctl_download;
    pend_d  = pend_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rad_d   = rad_q;
    rdt_d   = rdt_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    seen_d  = seen_q;
    bad_d   = bad_q;
    swp_d   = swp_q;
    type_d  = type_q;
    valid_d = valid_q;

    if (issue) begin
      pend_d = 1'b0;
      rad_d  = adr_q;
      rdt_d  = dat_q;
      if (cnt_q != '1) cnt_d = cnt_q + 25'd1;
      if (in_tbl) seen_d = 1'b1;
      if (in_swp) begin
        if (dat_q >= SWP_MAX) bad_d = 1'b1;
        else if (swp_q != 8'hFF) swp_d = swp_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (dl_rise) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
          seen_d  = 1'b0;
          bad_d   = 1'b0;
          swp_d   = '0;
          type_d  = 2'd0;
          valid_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.ioctl_wr) begin
          if (pend_q) begin
            err_d = 1'b1;
          end else begin
            adr_d  = bus.ioctl_addr;
            dat_d  = bus.ioctl_dout;
            pend_d = 1'b1;
          end
        end
        if (!bus.ioctl_download) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!pend_q) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_DONE;
        valid_d = 1'b1;
        if (!seen_q) type_d = 2'd0;
        else if ((swp_q >= 8'd128) && !bad_q) type_d = 2'd2;
        else type_d = 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dl_q    <= 1'b0;
      pend_q  <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rad_q   <= '0;
      rdt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      seen_q  <= 1'b0;
      bad_q   <= 1'b0;
      swp_q   <= '0;
      type_q  <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= dl_d;
      pend_q  <= pend_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rad_q   <= rad_d;
      rdt_q   <= rdt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      bad_q   <= bad_d;
      swp_q   <= swp_d;
      type_q  <= type_d;
      valid_q <= valid_d;
    end
  end

  // The bus shows the holding register only while writing; otherwise the last issued byte.
  assign bus.ROMAD      = issue ? adr_q : rad_q;
  assign bus.ROMDT      = issue ? dat_q : rdt_q;
  assign bus.ROMEN      = issue;
  assign bus.ioctl_wait = pend_q;

  assign dec_type  = type_q;
  assign dec_valid = valid_q;
  assign byte_cnt  = cnt_q;
  assign err_ovr   = err_q;

endmodule

// File: tb/tb_segasys1_romload.sv
// Bench for segasys1_romload: random download images scored against a queue of expected writes
// and a table classifier computed directly from the address/data rules.
`timescale 1ns/1ps
module tb_segasys1_romload;

  localparam logic [24:0] TBL = 25'h2C100;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        romcl;
  logic [1:0]  dec_type;
  logic        dec_valid;
  logic [24:0] byte_cnt;
  logic        err_ovr;

  segasys1_romload_if bus();

  segasys1_romload dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ROMCL     (romcl),
    .dec_type  (dec_type),
    .dec_valid (dec_valid),
    .byte_cnt  (byte_cnt),
    .err_ovr   (err_ovr)
  );

  always #5 clk = ~clk;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  wr_t  exp_q[$];
  wr_t  plan[$];
  bit   rnd_rdy = 1'b0;
  logic s_en, s_wait, s_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sample at the falling edge, score any ROM write, then return just after the rising edge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    s_en    = bus.ROMEN;
    s_wait  = bus.ioctl_wait;
    s_valid = dec_valid;
    if (bus.ROMEN === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("romen_unexpected", 32'(bus.ROMEN), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("romad", 32'(bus.ROMAD), 32'(e.addr));
        chk("romdt", 32'(bus.ROMDT), 32'(e.data));
      end
    end
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.ROMRDY = ($urandom_range(0, 3) != 0);
  endtask

  function automatic logic [1:0] ref_type(input wr_t pl[$]);
    bit seen = 1'b0;
    bit bad  = 1'b0;
    int cnt  = 0;
    int o;
    foreach (pl[i]) begin
      o = int'(pl[i].addr) - int'(TBL);
      if (o >= 0 && o < 256) begin
        seen = 1'b1;
        if (o >= 128) begin
          if (pl[i].data >= 8'd24) bad = 1'b1;
          else cnt++;
        end
      end
    end
    if (!seen) return 2'd0;
    if (cnt >= 128 && !bad) return 2'd2;
    return 2'd1;
  endfunction

  task automatic host_wr(input wr_t w);
    int guard = 0;
    while (bus.ioctl_wait === 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) chk("wait_timeout", 32'(bus.ioctl_wait), 32'd0);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = w.addr;
    bus.ioctl_dout = w.data;
    exp_q.push_back(w);
    tick();
    bus.ioctl_wr = 1'b0;
    if (!rnd_rdy) begin
      tick();
      chk("latency_1cyc", 32'(s_en), 32'd1);
    end
  endtask

  task automatic start_dl();
    bus.ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic finish_dl(input logic [1:0] et, input int n, input logic eerr);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 500) begin
      tick();
      guard++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    bus.ioctl_download = 1'b0;
    tick();
    tick();
    tick();
    chk("valid_early", 32'(s_valid), 32'd0);
    tick();
    chk("valid", 32'(s_valid), 32'd1);
    chk("dec_type", 32'(dec_type), 32'(et));
    chk("byte_cnt", 32'(byte_cnt), 32'(n));
    chk("err_ovr", 32'(err_ovr), 32'(eerr));
  endtask

  task automatic run_plan(input logic [1:0] et);
    start_dl();
    foreach (plan[i]) host_wr(plan[i]);
    finish_dl(et, plan.size(), 1'b0);
    chk("romad_hold", 32'(bus.ROMAD), 32'(plan[plan.size()-1].addr));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_romad"}, 32'(bus.ROMAD), 32'd0);
    chk({tag, "_romdt"}, 32'(bus.ROMDT), 32'd0);
    chk({tag, "_romen"}, 32'(bus.ROMEN), 32'd0);
    chk({tag, "_wait"}, 32'(bus.ioctl_wait), 32'd0);
    chk({tag, "_type"}, 32'(dec_type), 32'd0);
    chk({tag, "_valid"}, 32'(dec_valid), 32'd0);
    chk({tag, "_cnt"}, 32'(byte_cnt), 32'd0);
    chk({tag, "_err"}, 32'(err_ovr), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t w;
    int  wcnt;

    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ROMRDY         = 1'b0;

    // Reset state, then reset while a byte is held with ROMRDY high.
    repeat (3) tick();
    check_idle_outputs("rst");
    chk("romcl", 32'(romcl), 32'(clk));
    rst_n = 1'b1;
    tick();
    start_dl();
    w.addr = 25'h00123; w.data = 8'h5A;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = w.addr; bus.ioctl_dout = w.data;
    tick();
    bus.ioctl_wr = 1'b0;
    tick();
    chk("pending_wait", 32'(s_wait), 32'd1);
    rst_n = 1'b0;
    bus.ROMRDY = 1'b1;
    bus.ioctl_download = 1'b0;
    exp_q.delete();
    repeat (4) begin
      tick();
      chk("rst_no_romen", 32'(s_en), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_romen", 32'(s_en), 32'd0);
    check_idle_outputs("post_rst");

    // Plain image below the table region, ROMRDY always high.
    rnd_rdy = 1'b0; bus.ROMRDY = 1'b1;
    plan.delete();
    for (int i = 0; i < 2048; i++) begin
      w.addr = 25'(i); w.data = 8'($urandom_range(0, 255));
      plan.push_back(w);
    end
    run_plan(2'd0);

    // Table image with in-range swap entries, then with one out-of-range entry.
    for (int v = 0; v < 2; v++) begin
      rnd_rdy = 1'b1;
      plan.delete();
      for (int a = 32'h2C000; a <= 32'h2C1FF; a++) begin
        w.addr = 25'(a);
        if (a >= 32'h2C180) w.data = 8'((a - 32'h2C180) % 24);
        else w.data = 8'($urandom_range(0, 255));
        if (v == 1 && a == 32'h2C1A5) w.data = 8'd24;
        plan.push_back(w);
      end
      run_plan(v == 0 ? 2'd2 : 2'd1);
    end

    // Random images scored against the reference classifier.
    for (int mode = 0; mode < 4; mode++) begin
      rnd_rdy = 1'b1;
      plan.delete();
      for (int i = 0; i < 200; i++) begin
        case (mode)
          0: begin
            w.addr = 25'($urandom_range(0, 32'h2C0FF));
            w.data = 8'($urandom_range(0, 255));
          end
          1: begin
            if (i % 5 == 0) begin
              w.addr = TBL + 25'($urandom_range(0, 127));
              w.data = 8'($urandom_range(0, 255));
            end else begin
              w.addr = TBL + 25'($urandom_range(128, 255));
              w.data = 8'($urandom_range(0, 23));
            end
          end
          2: begin
            w.addr = TBL - 25'd64 + 25'($urandom_range(0, 383));
            w.data = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 23));
          end
          default: begin
            if (i < 60) begin
              w.addr = TBL + 25'($urandom_range(128, 255));
              w.data = 8'($urandom_range(0, 23));
            end else begin
              w.addr = TBL + 25'd256 + 25'($urandom_range(0, 1000));
              w.data = 8'($urandom_range(0, 255));
            end
          end
        endcase
        plan.push_back(w);
      end
      run_plan(ref_type(plan));
    end

    // ROMRDY stall with an overrun strobe during the wait.
    rnd_rdy = 1'b0;
    start_dl();
    bus.ROMRDY = 1'b0;
    w.addr = 25'h01000; w.data = 8'hA7;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = w.addr; bus.ioctl_dout = w.data;
    exp_q.push_back(w);
    tick();
    bus.ioctl_addr = 25'h01FFF; bus.ioctl_dout = 8'h3C;
    wcnt = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 2) bus.ioctl_wr = 1'b0;
      if (i == 5) bus.ROMRDY = 1'b1;
      tick();
      if (s_wait) wcnt++;
      if (i == 5) chk("stall_romen", 32'(s_en), 32'd1);
      else if (i < 5) chk("stall_no_romen", 32'(s_en), 32'd0);
    end
    chk("wait_cycles", 32'(wcnt), 32'd5);
    chk("err_ovr_set", 32'(err_ovr), 32'd1);
    finish_dl(2'd0, 1, 1'b1);

    // Download ends with a held byte and ROMRDY low: stays in drain until ROMRDY returns.
    bus.ROMRDY = 1'b1;
    start_dl();
    for (int i = 0; i < 3; i++) begin
      w.addr = 25'h00400 + 25'(i); w.data = 8'($urandom_range(0, 255));
      host_wr(w);
    end
    bus.ROMRDY = 1'b0;
    w.addr = 25'h00500; w.data = 8'hC3;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = w.addr; bus.ioctl_dout = w.data;
    exp_q.push_back(w);
    tick();
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    repeat (10) tick();
    chk("drain_hold_valid", 32'(s_valid), 32'd0);
    chk("drain_hold_wait", 32'(s_wait), 32'd1);
    bus.ROMRDY = 1'b1;
    tick();
    chk("drain_romen", 32'(s_en), 32'd1);
    tick();
    tick();
    chk("drain_valid_early", 32'(s_valid), 32'd0);
    tick();
    chk("drain_valid", 32'(s_valid), 32'd1);
    chk("drain_byte_cnt", 32'(byte_cnt), 32'd4);
    bus.ioctl_download = 1'b1;
    tick();
    tick();
    chk("restart_valid", 32'(dec_valid), 32'd0);
    chk("restart_cnt", 32'(byte_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
